// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and constants for mem_access_master.
//   state_e      - access sequencer states
//   LatCntWidth  - width of the read-latency down-counter
//   MaxRdLatency - largest RD_LATENCY the counter can represent
package mem_access_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssueLo,
        StWaitLo,
        StIssueHi,
        StWaitHi,
        StResp
    } state_e;

    localparam int unsigned LatCntWidth  = 4;
    localparam int unsigned MaxRdLatency = 1 << LatCntWidth;

endpackage

// File: rtl/mem_access_master.sv
// mem_access_master: CPU-side initiator for the single-port memory block.
// Takes byte/word read and write requests over valid/ready, issues one memory
// access per byte (low byte first), waits out the read latency, assembles the
// little-endian word and holds the response until it is consumed.
//
// Optional build macro: MEM_ACCESS_PAGE_WRAP_EN
//   defined   - word hi address increments only bits [7:0] (6502 JMP (ind) quirk)
//   undefined - word hi address is a full-width increment
//
// Ports:
//   clk_i, resetn_i           clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake
//   req_write_i, req_word_i   access kind and size
//   req_addr_i, req_wdata_i   byte address, write data (low byte to req_addr_i)
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_rdata_o               read data (byte reads zero-extended, writes return 0)
//   mem_rd_enable_o           memory port enable, high for reads and writes
//   mem_wr_enable_o           memory write strobe
//   mem_addr_o, mem_wr_data_o memory address and write data
//   mem_rd_data_i             memory read data
module mem_access_master
    import mem_access_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic                    req_word_i,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [2*DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                    mem_rd_enable_o,
    output logic                    mem_wr_enable_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wr_data_o,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data_i
);

    localparam logic [LatCntWidth-1:0] LatReload = LatCntWidth'(RD_LATENCY - 1);

    // Address of the high byte of a word access.
    function automatic logic [ADDR_WIDTH-1:0] hi_addr(input logic [ADDR_WIDTH-1:0] addr);
`ifdef MEM_ACCESS_PAGE_WRAP_EN
        logic [7:0] low;
        low = addr[7:0] + 8'd1;
        return {addr[ADDR_WIDTH-1:8], low};
`else
        return addr + ADDR_WIDTH'(1);
`endif
    endfunction

    state_e                  state_q;
    logic [LatCntWidth-1:0]  lat_cnt_q;
    logic                    write_q;
    logic                    word_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_hi_q;
    logic [2*DATA_WIDTH-1:0] rdata_q;
    logic                    req_ready_q;
    logic                    rsp_valid_q;
    logic                    mem_rd_enable_q;
    logic                    mem_wr_enable_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wr_data_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q         <= StIdle;
            lat_cnt_q       <= '0;
            write_q         <= 1'b0;
            word_q          <= 1'b0;
            addr_q          <= '0;
            wdata_hi_q      <= '0;
            rdata_q         <= '0;
            req_ready_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            mem_rd_enable_q <= 1'b0;
            mem_wr_enable_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wr_data_q   <= '0;
        end else begin
            // Memory outputs are single-cycle pulses; only ISSUE states drive them.
            mem_rd_enable_q <= 1'b0;
            mem_wr_enable_q <= 1'b0;
            mem_addr_q      <= '0;
            mem_wr_data_q   <= '0;

            unique case (state_q)
                StIdle: begin
                    req_ready_q <= 1'b1;
                    if (req_valid_i && req_ready_q) begin
                        write_q         <= req_write_i;
                        word_q          <= req_word_i;
                        addr_q          <= req_addr_i;
                        wdata_hi_q      <= req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH];
                        rdata_q         <= '0;
                        req_ready_q     <= 1'b0;
                        mem_rd_enable_q <= 1'b1;
                        mem_wr_enable_q <= req_write_i;
                        mem_addr_q      <= req_addr_i;
                        mem_wr_data_q   <= req_wdata_i[DATA_WIDTH-1:0];
                        state_q         <= StIssueLo;
                    end
                end

                StIssueLo: begin
                    if (!write_q) begin
                        lat_cnt_q <= LatReload;
                        state_q   <= StWaitLo;
                    end else if (word_q) begin
                        mem_rd_enable_q <= 1'b1;
                        mem_wr_enable_q <= 1'b1;
                        mem_addr_q      <= hi_addr(addr_q);
                        mem_wr_data_q   <= wdata_hi_q;
                        state_q         <= StIssueHi;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end

                StWaitLo: begin
                    if (lat_cnt_q == '0) begin
                        rdata_q[DATA_WIDTH-1:0] <= mem_rd_data_i;
                        if (word_q) begin
                            mem_rd_enable_q <= 1'b1;
                            mem_addr_q      <= hi_addr(addr_q);
                            state_q         <= StIssueHi;
                        end else begin
                            rsp_valid_q <= 1'b1;
                            state_q     <= StResp;
                        end
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end

                StIssueHi: begin
                    if (write_q) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        lat_cnt_q <= LatReload;
                        state_q   <= StWaitHi;
                    end
                end

                StWaitHi: begin
                    if (lat_cnt_q == '0) begin
                        rdata_q[2*DATA_WIDTH-1:DATA_WIDTH] <= mem_rd_data_i;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end

                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o     = req_ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rdata_q;
    assign mem_rd_enable_o = mem_rd_enable_q;
    assign mem_wr_enable_o = mem_wr_enable_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wr_data_o   = mem_wr_data_q;

endmodule
